div_unit: RTL and testbench

- Iterative RV32M divider executing DIV, DIVU, REM and REMU. It is the inverse-direction companion to the combinational ALU.
- Sits beside the ALU in the execute stage. Control holds the core stalled while `busy` is high and resumes when the result handshake completes.
- Uses a restoring algorithm that produces one quotient bit per cycle. Divide-by-zero and signed overflow are resolved on a fast path.

---
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative restoring RV32M divider (DIV/DIVU/REM/REMU), one
//            quotient bit per cycle, fast path for divide-by-zero/overflow.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  c_all_ones = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] c_last_it  = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_dsr;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_last;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_quo_sh;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_signed   = ~div_op[0];
  assign w_a_neg    = w_signed & dividend[XLEN-1];
  assign w_b_neg    = w_signed & divisor[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag    = w_b_neg ? (~divisor + 1'b1) : divisor;
  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed & (dividend == c_int_min) & (divisor == c_all_ones);
  assign w_last     = (r_cnt == c_last_it);

  // rem < divisor, so rem_sh - divisor always fits in XLEN+1 signed bits;
  // the top bit of the trial is therefore a true sign bit.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_quo_sh = {r_quo[XLEN-2:0], 1'b0};
  assign w_trial  = w_rem_sh - {1'b0, r_dsr};

  assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign div_result = r_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (flush || out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_rem <= div_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dsr    <= w_b_mag;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_cnt    <= '0;
            if (w_div_zero) begin
              r_result <= div_op[1] ? dividend : c_all_ones;
            end else if (w_ovf) begin
              r_result <= div_op[1] ? '0 : c_int_min;
            end
          end
        end
        S_CALC: begin
          if (!w_trial[XLEN]) begin
            r_rem <= w_trial[XLEN-1:0];
            r_quo <= {w_quo_sh[XLEN-1:1], 1'b1};
          end else begin
            r_rem <= w_rem_sh[XLEN-1:0];
            r_quo <= w_quo_sh;
          end
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_result <= r_is_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Self-checking bench for div_unit: vector table, corner sequences
//            and randomised scoreboard run against a RISC-V M reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] div_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_op     (div_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_result (div_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    sgn = ~op[0];
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // One complete transaction; latency is counted in cycles with the accept cycle as 0.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int gap,
                        input bit noisy);
    int          lat;
    logic [31:0] held;
    logic [31:0] e;
    @(negedge clk);
    div_op    = op;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (gap == 0);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    div_op   = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("timeout", 32'(out_valid), 32'd1);
      void'(exp_q.pop_front());
      out_ready = 1'b0;
      return;
    end
    if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
    if (gap > 0) begin
      held = div_result;
      repeat (gap) begin
        @(posedge clk);
        #1;
        check("backpressure_hold", {out_valid, div_result[30:0]}, {1'b1, held[30:0]});
      end
      out_ready = 1'b1;
    end
    e = exp_q.pop_front();
    check("result", div_result, e);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_handshake", {29'd0, out_valid, busy, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_div_result"}, div_result, 32'd0);
  endtask

  initial begin
    vec_t vecs[15];
    int   seen;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[5]  = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
    vecs[6]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
    vecs[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34};
    vecs[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    vecs[13] = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[14] = '{2'b10, 32'd5,          32'd0,          32'd5,          1};

    rst_n = 1'b0; in_valid = 1'b0; div_op = 2'b00; dividend = '0; divisor = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, 1'b0);

    // Backpressure: result held for 10 cycles in DONE.
    run_op(2'b01, 32'd1000, 32'd33, 32'd30, 34, 10, 1'b0);

    // Flush partway through CALC discards the operation.
    @(negedge clk);
    div_op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_state", {29'd0, out_valid, busy, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    div_op = 2'b01; dividend = 32'd10; divisor = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_blocks", 32'(busy), 32'd0);

    // Flush in DONE drops the pending result.
    @(negedge clk);
    div_op = 2'b00; dividend = 32'd5; divisor = 32'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("fast_done_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done_state", {29'd0, out_valid, busy, in_ready}, 32'd1);

    // Reset mid-CALC.
    @(negedge clk);
    div_op = 2'b00; dividend = 32'd12345; divisor = 32'd17; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_calc");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 1000; n++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          gap;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: b = 32'($urandom_range(1, 16));
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_op(op, a, b, ref_div(op, a, b), ref_lat(op, a, b), gap, 1'b1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
